// File: rtl/max7219_display.sv
// MAX7219 daisy-chain hex debug display: init sequence, then continuous digit refresh.
// Optional MAX7219_DP_EN: set DP on low-nibble digits to separate bytes.
module max7219_display #(
  parameter int NUM_CASCADES = 2,
  parameter int INTENSITY    = 1,
  parameter int CLK_DIV      = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [7:0]  frame [4*NUM_CASCADES],
  output logic        spi_clk,
  output logic        dout,
  output logic        cs,
  output logic        stop,
  output logic [10:1] pin
);

  localparam int NB       = 16 * NUM_CASCADES;
  localparam int GAP      = 2 * CLK_DIV;
  localparam int GAP_IDLE = (GAP > 3) ? GAP - 3 : 0;
  localparam int DW       = $clog2(GAP + 1);
  localparam int BW       = $clog2(NB + 1);
  localparam int GW       = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NB-1:0]   sr_q, sr_d;
  logic [2:0]      idx_q, idx_d;
  logic            init_q, init_d;
  logic            spi_clk_q, spi_clk_d;
  logic            dout_q, dout_d;
  logic            cs_q, cs_d;

  logic [NB-1:0]   words;
  logic [DW-1:0]   div_inc;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'h7E;
      4'h1: s = 8'h30;
      4'h2: s = 8'h6D;
      4'h3: s = 8'h79;
      4'h4: s = 8'h33;
      4'h5: s = 8'h5B;
      4'h6: s = 8'h5F;
      4'h7: s = 8'h70;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h7B;
      4'hA: s = 8'h77;
      4'hB: s = 8'h1F;
      4'hC: s = 8'h4E;
      4'hD: s = 8'h3D;
      4'hE: s = 8'h4F;
      default: s = 8'h47;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] init_word(input logic [2:0] i);
    logic [15:0] w;
    unique case (i)
      3'd0:    w = 16'h0F00;
      3'd1:    w = 16'h0C01;
      3'd2:    w = 16'h0900;
      3'd3:    w = 16'h0B07;
      default: w = {8'h0A, 4'h0, 4'(INTENSITY)};
    endcase
    return w;
  endfunction

  // Build the per-chip words for the next transfer; farthest chip sits at the MSBs.
  always_comb begin
    logic [7:0] b;
    logic [3:0] nib;
    logic [7:0] seg;
    logic [7:0] addr;
    words = '0;
    b     = '0;
    nib   = '0;
    seg   = '0;
    addr  = 8'd8 - {5'b0, idx_q};
    for (int k = 0; k < NUM_CASCADES; k++) begin
      b   = frame[4*k + int'(idx_q[2:1])];
      nib = idx_q[0] ? b[3:0] : b[7:4];
      seg = hex_seg(nib);
`ifdef MAX7219_DP_EN
      if (idx_q[0]) seg[7] = 1'b1;
`endif
      words[16*k +: 16] = init_q ? init_word(idx_q) : {addr, seg};
    end
  end

  assign div_inc = div_q + 1'b1;

  // Transfer sequencer: gap, snapshot, bit shifting, latch and step advance.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    sr_d      = sr_q;
    idx_d     = idx_q;
    init_d    = init_q;
    spi_clk_d = spi_clk_q;
    dout_d    = dout_q;
    cs_d      = cs_q;
    unique case (state_q)
      IDLE: begin
        if (gap_q >= GW'(GAP_IDLE)) begin
          state_d = LOAD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      LOAD: begin
        sr_d      = words;
        dout_d    = words[NB-1];
        cs_d      = 1'b0;
        spi_clk_d = 1'b0;
        div_d     = '0;
        bit_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (div_q == DW'(GAP - 1)) begin
          div_d     = '0;
          spi_clk_d = 1'b0;
          if (bit_q == BW'(NB - 1)) begin
            state_d = LATCH;
            cs_d    = 1'b1;
            dout_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 1'b1;
            sr_d   = {sr_q[NB-2:0], 1'b0};
            dout_d = sr_q[NB-2];
          end
        end else begin
          div_d     = div_inc;
          spi_clk_d = (div_inc >= DW'(CLK_DIV));
        end
      end
      default: begin
        gap_d   = '0;
        state_d = (GAP > 2) ? IDLE : LOAD;
        if (init_q) begin
          if (idx_q == 3'd4) begin
            init_d = 1'b0;
            idx_d  = 3'd0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer and restarts init.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      sr_q      <= '0;
      idx_q     <= '0;
      init_q    <= 1'b1;
      spi_clk_q <= 1'b0;
      dout_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      sr_q      <= sr_d;
      idx_q     <= idx_d;
      init_q    <= init_d;
      spi_clk_q <= spi_clk_d;
      dout_q    <= dout_d;
      cs_q      <= cs_d;
    end
  end

  assign spi_clk = spi_clk_q;
  assign dout    = dout_q;
  assign cs      = cs_q;
  assign stop    = cs_q;
  assign pin     = {2'b00, init_q, idx_q, cs_q, cs_q, dout_q, spi_clk_q};

endmodule

// File: tb/tb_max7219_display.sv
// Scoreboard bench for max7219_display: expected transfers queued by stimulus,
// decoded from the serial bus and compared by an independent monitor.
module tb_max7219_display;

  localparam int N  = 2;
  localparam int CD = 4;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  frame [4*N];
  logic        spi_clk, dout, cs, stop;
  logic [10:1] pin;

  max7219_display #(.NUM_CASCADES(N), .INTENSITY(1), .CLK_DIV(CD)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .frame  (frame),
    .spi_clk(spi_clk),
    .dout   (dout),
    .cs     (cs),
    .stop   (stop),
    .pin    (pin)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_done = 0;
  int nbits = 0;
  logic in_xfer = 1'b0;
  logic [31:0] expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dp(input logic [7:0] v);
`ifdef MAX7219_DP_EN
    return v | 8'h80;
`else
    return v;
`endif
  endfunction

  // Hand-computed refresh words for one pass with only frame[0] and frame[4] non-zero.
  task automatic push_pass(input logic [7:0] a8c0, input logic [7:0] a7c0);
    expq.push_back({8'h08, 8'h77, 8'h08, a8c0});
    expq.push_back({8'h07, dp(8'h47), 8'h07, a7c0});
    expq.push_back(32'h067E067E);
    expq.push_back({8'h05, dp(8'h7E), 8'h05, dp(8'h7E)});
    expq.push_back(32'h047E047E);
    expq.push_back({8'h03, dp(8'h7E), 8'h03, dp(8'h7E)});
    expq.push_back(32'h027E027E);
    expq.push_back({8'h01, dp(8'h7E), 8'h01, dp(8'h7E)});
  endtask

  task automatic push_init();
    expq.push_back(32'h0F000F00);
    expq.push_back(32'h0C010C01);
    expq.push_back(32'h09000900);
    expq.push_back(32'h0B070B07);
    expq.push_back(32'h0A010A01);
  endtask

  task automatic wait_xfers(input int n);
    int t;
    t = 0;
    while (xfer_done < n && t < 400 * 30) begin
      @(negedge sysclk);
      t++;
    end
    chk("xfer_count", 32'(xfer_done), 32'(n));
  endtask

  // Monitor: decodes dout on spi_clk rising edges while cs is low.
  initial begin
    logic cs_p, sck_p, skip_gap;
    logic [31:0] sh;
    int since, low_cnt, high_cnt, per_bad, stop_bad;
    cs_p = 1'b1; sck_p = 1'b0; skip_gap = 1'b1;
    sh = '0; since = 0; low_cnt = 0; high_cnt = 0;
    per_bad = 0; stop_bad = 0;
    forever begin
      @(negedge sysclk);
      if (reset) begin
        in_xfer  = 1'b0;
        skip_gap = 1'b1;
        cs_p     = 1'b1;
        sck_p    = 1'b0;
        nbits    = 0;
      end else begin
        if (stop !== cs) stop_bad++;
        if (cs_p && !cs) begin
          if (!skip_gap) chk("gap_len", 32'(high_cnt), 32'(2*CD));
          skip_gap = 1'b0;
          in_xfer  = 1'b1;
          nbits    = 0;
          low_cnt  = 0;
          per_bad  = 0;
          stop_bad = 0;
          since    = 0;
        end
        if (!cs) begin
          low_cnt++;
          since++;
          if (!sck_p && spi_clk) begin
            if (nbits > 0 && since != 2*CD) per_bad++;
            since = 0;
            sh    = {sh[30:0], dout};
            nbits++;
          end
        end
        if (!cs_p && cs) begin
          if (expq.size() > 0) begin
            chk("xfer_word", sh, expq.pop_front());
            chk("bit_count", 32'(nbits), 32'(16*N));
            chk("cs_low_len", 32'(low_cnt), 32'(16*N*2*CD));
            chk("sck_period_err", 32'(per_bad), 32'd0);
            chk("stop_err", 32'(stop_bad), 32'd0);
            xfer_done++;
          end
          in_xfer  = 1'b0;
          high_cnt = 0;
        end
        if (cs) high_cnt++;
        cs_p  = cs;
        sck_p = spi_clk;
      end
    end
  end

  // Stimulus
  initial begin
    int t;
    for (int i = 0; i < 4*N; i++) frame[i] = 8'h00;
    frame[0] = 8'h12;
    frame[4] = 8'hAF;
    push_init();
    push_pass(8'h30, dp(8'h6D));
    push_pass(8'h30, dp(8'h33));
    expq.push_back(32'h08770879);

    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_spi_clk", 32'(spi_clk), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_stop", 32'(stop), 32'd1);
    chk("rst_pin", 32'(pin), 32'h08C);
    @(negedge sysclk);
    reset = 1'b0;
    t = 0;
    while (cs && t < 20) begin
      @(negedge sysclk);
      t++;
    end
    chk("cs_fall_late", 32'(t <= 2*CD + 2), 32'd1);
    chk("cs_fall", 32'(cs), 32'd0);

    wait_xfers(13);
    t = 0;
    while (cs && t < 40) begin
      @(negedge sysclk);
      t++;
    end
    repeat (60) @(negedge sysclk);
    frame[0] = 8'h34;

    wait_xfers(22);
    t = 0;
    while (!(in_xfer && nbits == 10) && t < 600) begin
      @(negedge sysclk);
      t++;
    end
    chk("reach_bit10", 32'(nbits), 32'd10);
    push_init();
    expq.push_back(32'h08770879);
    reset = 1'b1;
    @(posedge sysclk);
    #1;
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_sck", 32'(spi_clk), 32'd0);
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    #1;
    chk("reinit_pin8", 32'(pin[8]), 32'd1);
    chk("reinit_idx", 32'(pin[7:5]), 32'd0);

    wait_xfers(28);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/max7219_display.md
Name: max7219_display

Overview:
- Drives a daisy chain of NUM_CASCADES MAX7219 8-digit 7-segment drivers over a 3-wire serial bus (CLK/DIN/LOAD).
- Each chip shows 4 bytes of the frame input as 8 hex digits.
- Used as a free-running debug display: it initialises the chips after reset, then refreshes all digits continuously from live frame data.

Parameters:
- NUM_CASCADES, 2: number of chained MAX7219 chips; frame holds 4*NUM_CASCADES bytes.
- INTENSITY, 1: 4-bit brightness value (0..15) written to register 0x0A.
- CLK_DIV, 4: sysclk cycles per spi_clk half-period. spi_clk = sysclk/(2*CLK_DIV).

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- frame  in  8 x [4*NUM_CASCADES]  unpacked byte array; frame[4k..4k+3] appear on chip k.
- spi_clk  out  1  MAX7219 CLK.
- dout  out  1  MAX7219 DIN.
- cs  out  1  MAX7219 LOAD/CS, active low.
- stop  out  1  high while no transfer is in progress (cs high).
- pin  out  10 [10:1]  debug mirror: pin[1]=spi_clk, pin[2]=dout, pin[3]=cs, pin[4]=stop, pin[7:5]=current digit index, pin[8]=init phase active, pin[10:9]=0.

Behaviour:
- Reset: spi_clk=0, dout=0, cs=1, stop=1, pin reflects these. Reset mid-transfer aborts it; cs=1 on the next cycle; the init sequence restarts.
- Transfer: one 16-bit word {addr[7:0], data[7:0]} per chip, NUM_CASCADES words per transfer, MSB first.
  - The farthest chip's word (k=NUM_CASCADES-1) is shifted first; chip 0 (wired to dout) is shifted last.
  - cs falls, then each bit is presented on dout while spi_clk is low for CLK_DIV cycles; spi_clk is then high for CLK_DIV cycles (chip samples on rising edge).
  - After the last bit, spi_clk returns low, then cs rises; cs stays high for 2*CLK_DIV cycles (gap) before the next transfer.
  - Total transfer time: 16*NUM_CASCADES*2*CLK_DIV cycles plus the gap.
- States: IDLE/GAP (stop=1), LOAD (build words), SHIFT, LATCH. stop=0 from cs fall to cs rise.
- Init sequence after reset, each word broadcast to all chips:
  - 0x0F00 (display test off)
  - 0x0C01 (normal operation)
  - 0x0900 (no decode)
  - 0x0B07 (scan all 8 digits)
  - 0x0A{4'h0, INTENSITY}
- Refresh loop after init, forever: register addr 8,7,...,1, one transfer per addr, then wrap to 8.
- Snapshot: frame is sampled in LOAD at the start of each transfer; changes during SHIFT do not affect the words in flight.
- Digit mapping for chip k, byte j=0..3 (value b=frame[4k+j]):
  - b[7:4] goes to addr 8-2j.
  - b[3:0] goes to addr 7-2j.
  - Result: byte 0 is leftmost (addr 8,7), byte 3 is rightmost (addr 2,1).
- Hex font, segment byte {DP,A,B,C,D,E,F,G}, DP=0:
  - 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70
  - 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47
- All counters sized from parameters. Any NUM_CASCADES >= 1 is supported.

Optional Feature:
- Macro MAX7219_DP_EN.
- When defined: DP (bit 7) is set on every low-nibble digit (odd addresses 7,5,3,1), visually separating bytes. Example: nibble 1 at addr 7 sends 0xB0.
- When undefined: DP is always 0.

Test Plan:
- Reset check: hold reset 3 cycles -> spi_clk=0, dout=0, cs=1, stop=1. After release, cs falls within 2*CLK_DIV+2 cycles.
- First transfer, NUM_CASCADES=2, CLK_DIV=4:
  - Decoding dout on spi_clk rising edges gives 32 bits 0x0F000F00.
  - spi_clk period = 8 cycles; cs low for 256 cycles; stop=0 throughout.
- Init order: the 5 transfers decode as 0F00, 0C01, 0900, 0B07, then 0A01 (INTENSITY=1), each duplicated per chip.
- Refresh content: frame[0]=0x12, frame[4]=0xAF, others 0.
  - addr-8 transfer = 0x0877_0830: chip 1 'A' shifted first, chip 0 '1' last.
  - addr-7 transfer = 0x0747_076D.
- Reset mid-SHIFT: assert reset at bit 10 of the refresh -> cs=1 next cycle, then a full re-init starting with 0x0F00.
- Frame change mid-transfer: change frame[0] during SHIFT -> the current transfer keeps the old data; the next pass through that addr shows the new data.
